// File: rtl/ag_tcu_requant_pack_pkg.sv
// Shared definitions for the AG tensor core requantise/pack return path.
// The format encoding is shared with the fedp unit.
package ag_tcu_pkg;

    localparam logic [2:0] AG_FMT_I8 = 3'd1;
    localparam logic [2:0] AG_FMT_U8 = 3'd2;
    localparam logic [2:0] AG_FMT_I4 = 3'd3;
    localparam logic [2:0] AG_FMT_U4 = 3'd4;

    // Width of the rounded intermediate: 32-bit accumulator plus headroom for the bias
    localparam int unsigned RND_W = 41;

    // Any shift at or above this limit rounds every input to zero
    localparam logic [8:0] SHIFT_ZERO_LIM = 9'd40;

    function automatic logic fmt_valid(input logic [2:0] fmt);
        case (fmt)
            AG_FMT_I8, AG_FMT_U8, AG_FMT_I4, AG_FMT_U4: fmt_valid = 1'b1;
            default:                                    fmt_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] fmt_lanes(input logic [2:0] fmt);
        case (fmt)
            AG_FMT_I8, AG_FMT_U8: fmt_lanes = 4'd4;
            AG_FMT_I4, AG_FMT_U4: fmt_lanes = 4'd8;
            default:              fmt_lanes = 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] fmt_width(input logic [2:0] fmt);
        case (fmt)
            AG_FMT_I8, AG_FMT_U8: fmt_width = 4'd8;
            AG_FMT_I4, AG_FMT_U4: fmt_width = 4'd4;
            default:              fmt_width = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ag_tcu_requant_pack_if.sv
// Element input and packed-word output handshakes of the requant/pack unit.
interface ag_tcu_requant_pack_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_fmt;
    logic [8:0]      in_shift;
    logic [XLEN-1:0] in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [3:0]      out_count;

    modport master (
        output in_valid, in_fmt, in_shift, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_fmt, in_shift, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/ag_tcu_requant_pack_sat.sv
// Clamp a rounded value to the selected narrow format and flag clamping.
// The lane value is returned right-aligned in 8 bits, upper nibble zero for 4-bit formats.
module ag_tcu_requant_sat
    import ag_tcu_pkg::*;
(
    input  logic signed [RND_W-1:0] r_val,
    input  logic [2:0]              fmt,
    output logic [7:0]              lane,
    output logic                    sat
);

    logic signed [RND_W-1:0] lo_s;
    logic signed [RND_W-1:0] hi_s;
    logic [7:0]              mask_s;

    // Select the format range, then clamp against it
    always_comb begin
        lo_s   = '0;
        hi_s   = '0;
        mask_s = 8'h00;
        case (fmt)
            AG_FMT_I8: begin lo_s = -41'sd128; hi_s = 41'sd127; mask_s = 8'hFF; end
            AG_FMT_U8: begin lo_s = 41'sd0;    hi_s = 41'sd255; mask_s = 8'hFF; end
            AG_FMT_I4: begin lo_s = -41'sd8;   hi_s = 41'sd7;   mask_s = 8'h0F; end
            AG_FMT_U4: begin lo_s = 41'sd0;    hi_s = 41'sd15;  mask_s = 8'h0F; end
            default:   begin lo_s = '0;        hi_s = '0;       mask_s = 8'h00; end
        endcase
        if (!fmt_valid(fmt)) begin
            lane = 8'h00;
            sat  = 1'b0;
        end else if (r_val > hi_s) begin
            lane = hi_s[7:0] & mask_s;
            sat  = 1'b1;
        end else if (r_val < lo_s) begin
            lane = lo_s[7:0] & mask_s;
            sat  = 1'b1;
        end else begin
            lane = r_val[7:0] & mask_s;
            sat  = 1'b0;
        end
    end

endmodule

// File: rtl/ag_tcu_requant_pack.sv
// Requantise 32-bit accumulators (round-half-up shift, saturate) and pack them
// little-endian into XLEN writeback words. Two stages: S1 round, S2 saturate+pack.
module ag_tcu_requant_pack
    import ag_tcu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SAT_CNTW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    ag_tcu_requant_pack_if.slave  bus,
    output logic [SAT_CNTW-1:0]   sat_count,
    output logic                  fmt_err
);

    // Bits above the 32-bit packed payload read as all ones on wider XLEN
    localparam logic [XLEN-1:0] HI_ONES = ~XLEN'({1'b0, 32'hFFFF_FFFF});

    logic                    s1_valid_r;
    logic [2:0]              s1_fmt_r;
    logic                    s1_last_r;
    logic signed [RND_W-1:0] s1_val_r;

    logic [2:0]              word_fmt_r;
    logic [3:0]              lane_cnt_r;
    logic [31:0]             pack_r;
    logic                    out_valid_r;
    logic [XLEN-1:0]         out_data_r;
    logic [3:0]              out_count_r;
    logic [SAT_CNTW-1:0]     sat_count_r;
    logic                    fmt_err_r;

    logic                    en_s;
    logic                    flush_s;
    logic signed [RND_W-1:0] sext_s;
    logic signed [RND_W-1:0] bias_s;
    logic signed [RND_W-1:0] round_s;
    logic [7:0]              lane_val_s;
    logic                    sat_s;
    logic [4:0]              pos_s;
    logic [31:0]             new_pack_s;
    logic                    done_s;

    assign en_s         = !(out_valid_r && !bus.out_ready);
    assign flush_s      = s1_valid_r && (s1_fmt_r != word_fmt_r) && (lane_cnt_r != 4'd0);
    assign bus.in_ready = en_s && !flush_s;

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_count = out_count_r;
    assign sat_count     = sat_count_r;
    assign fmt_err       = fmt_err_r;

    // Round-half-up arithmetic right shift of the incoming accumulator
    always_comb begin
        sext_s  = {{(RND_W-32){bus.in_data[31]}}, bus.in_data[31:0]};
        bias_s  = '0;
        round_s = '0;
        if (bus.in_shift >= SHIFT_ZERO_LIM) begin
            round_s = '0;
        end else begin
            if (bus.in_shift != 9'd0) begin
                bias_s = signed'(41'd1 << (bus.in_shift - 9'd1));
            end else begin
                bias_s = '0;
            end
            round_s = (sext_s + bias_s) >>> bus.in_shift[5:0];
        end
    end

    ag_tcu_requant_sat u_sat (
        .r_val (s1_val_r),
        .fmt   (s1_fmt_r),
        .lane  (lane_val_s),
        .sat   (sat_s)
    );

    // Place the saturated lane at its bit position and decide word completion
    always_comb begin
        if (fmt_width(s1_fmt_r) == 4'd8) begin
            pos_s = {lane_cnt_r[1:0], 3'b000};
        end else begin
            pos_s = {lane_cnt_r[2:0], 2'b00};
        end
        new_pack_s = pack_r | ({24'h000000, lane_val_s} << pos_s);
        done_s     = ((lane_cnt_r + 4'd1) == fmt_lanes(s1_fmt_r)) || s1_last_r;
    end

    // S1 capture; held during a flush so the element opens the next word
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_fmt_r   <= 3'd0;
            s1_last_r  <= 1'b0;
            s1_val_r   <= '0;
            fmt_err_r  <= 1'b0;
        end else if (en_s && !flush_s) begin
            s1_valid_r <= bus.in_valid && fmt_valid(bus.in_fmt);
            s1_fmt_r   <= bus.in_fmt;
            s1_last_r  <= bus.in_last;
            s1_val_r   <= round_s;
            if (bus.in_valid && !fmt_valid(bus.in_fmt)) begin
                fmt_err_r <= 1'b1;
            end
        end
    end

    // S2 pack/lane sequencing, output word register and clamp counter
    always_ff @(posedge clk) begin
        if (reset) begin
            word_fmt_r  <= 3'd0;
            lane_cnt_r  <= 4'd0;
            pack_r      <= 32'h0000_0000;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_count_r <= 4'd0;
            sat_count_r <= '0;
        end else if (en_s) begin
            out_valid_r <= 1'b0;
            if (s1_valid_r) begin
                if (flush_s) begin
                    out_data_r  <= HI_ONES | XLEN'(pack_r);
                    out_count_r <= lane_cnt_r;
                    out_valid_r <= 1'b1;
                    lane_cnt_r  <= 4'd0;
                    pack_r      <= 32'h0000_0000;
                end else begin
                    if (lane_cnt_r == 4'd0) begin
                        word_fmt_r <= s1_fmt_r;
                    end
                    if (sat_s && (sat_count_r != {SAT_CNTW{1'b1}})) begin
                        sat_count_r <= sat_count_r + SAT_CNTW'(1);
                    end
                    if (done_s) begin
                        out_data_r  <= HI_ONES | XLEN'(new_pack_s);
                        out_count_r <= lane_cnt_r + 4'd1;
                        out_valid_r <= 1'b1;
                        lane_cnt_r  <= 4'd0;
                        pack_r      <= 32'h0000_0000;
                    end else begin
                        pack_r     <= new_pack_s;
                        lane_cnt_r <= lane_cnt_r + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ag_tcu_requant_pack.sv
// Directed bench for ag_tcu_requant_pack: expected words are queued as stimulus
// is issued and a negedge monitor pops and compares each delivered word.
module tb_ag_tcu_requant_pack;
    import ag_tcu_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sat_count;
    logic        fmt_err;

    ag_tcu_requant_pack_if #(.XLEN(XLEN)) bus ();

    ag_tcu_requant_pack #(.XLEN(XLEN), .SAT_CNTW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sat_count (sat_count),
        .fmt_err   (fmt_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  count;
    } word_t;

    word_t       exp_q[$];
    word_t       w_pop;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          stall_cnt = 0;
    int          hold_seen = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] c);
        word_t w;
        w.data  = d;
        w.count = c;
        exp_q.push_back(w);
    endtask

    task automatic send(input logic [2:0] fmt, input logic [8:0] sh,
                        input logic [31:0] d, input logic last);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_fmt   = fmt;
        bus.in_shift = sh;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int g = 0; g < 200 && !done; g++) begin
            @(negedge clk);
            done = bus.in_ready;
            if (!done) stall_cnt++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never high, expected acceptance");
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int g = 0; g < 40 && exp_q.size() != 0; g++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pop and compare on each delivered word, check stall behaviour
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'(bus.out_data), 64'(prev_data));
                check("hold_count", 64'(bus.out_count), 64'(prev_cnt));
            end
            if (bus.out_valid && !bus.out_ready) begin
                hold_seen++;
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h count %0d, expected no word",
                             bus.out_data, bus.out_count);
                end else begin
                    w_pop = exp_q.pop_front();
                    check("word_data", 64'(bus.out_data), 64'(w_pop.data));
                    check("word_count", 64'(bus.out_count), 64'(w_pop.count));
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_cnt  = bus.out_count;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_fmt    = 3'd0;
        bus.in_shift  = 9'd0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_count", 64'(bus.out_count), 64'd0);
        check("rst_sat_count", 64'(sat_count), 64'd0);
        check("rst_fmt_err", 64'(fmt_err), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // i8 shift 0, plus two-cycle latency from the completing accept
        push(32'h807F_FE01, 4'd4);
        send(AG_FMT_I8, 9'd0, 32'd1, 1'b0);
        send(AG_FMT_I8, 9'd0, -32'sd2, 1'b0);
        send(AG_FMT_I8, 9'd0, 32'd127, 1'b0);
        send(AG_FMT_I8, 9'd0, -32'sd128, 1'b0);
        idle();
        @(negedge clk);
        check("latency_t1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("latency_t2", 64'(bus.out_valid), 64'd1);
        drain();
        check("sat_after_i8", 64'(sat_count), 64'd0);

        // i8 shift 4: half-up rounding and clamping both ways
        push(32'h807F_FF02, 4'd4);
        send(AG_FMT_I8, 9'd4, 32'd24, 1'b0);
        send(AG_FMT_I8, 9'd4, -32'sd24, 1'b0);
        send(AG_FMT_I8, 9'd4, 32'd4800, 1'b0);
        send(AG_FMT_I8, 9'd4, -32'sd4800, 1'b0);
        idle();
        drain();
        check("sat_after_round", 64'(sat_count), 64'd2);

        // u4 full word of 8 lanes, then a clamped single-lane word
        push(32'h7654_3210, 4'd8);
        push(32'h0000_0000, 4'd1);
        for (int i = 0; i < 8; i++) send(AG_FMT_U4, 9'd0, 32'(i), 1'b0);
        send(AG_FMT_U4, 9'd0, -32'sd5, 1'b1);
        idle();
        drain();
        check("sat_after_u4", 64'(sat_count), 64'd3);

        // i4 partial word closed by last
        push(32'h0000_0F21, 4'd3);
        send(AG_FMT_I4, 9'd0, 32'd1, 1'b0);
        send(AG_FMT_I4, 9'd0, 32'd2, 1'b0);
        send(AG_FMT_I4, 9'd0, -32'sd1, 1'b1);
        idle();
        drain();

        // Format change flushes the partial word; invalid fmt is dropped
        push(32'h0000_0605, 4'd2);
        push(32'h0000_0009, 4'd1);
        stall_cnt = 0;
        send(AG_FMT_I8, 9'd0, 32'd5, 1'b0);
        send(AG_FMT_I8, 9'd0, 32'd6, 1'b0);
        send(AG_FMT_U4, 9'd0, 32'd9, 1'b1);
        send(3'd6, 9'd0, 32'd77, 1'b1);
        idle();
        check("flush_stall_cycles", 64'(stall_cnt), 64'd1);
        drain();
        check("fmt_err_set", 64'(fmt_err), 64'd1);
        check("sat_after_flush", 64'(sat_count), 64'd3);

        // Streaming with a 5-cycle downstream stall
        push(32'h0403_0201, 4'd4);
        push(32'h0807_0605, 4'd4);
        push(32'h0C0B_0A09, 4'd4);
        hold_seen = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) send(AG_FMT_I8, 9'd0, 32'(i + 1), 1'b0);
                idle();
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stall_observed", 64'(hold_seen != 0), 64'd1);

        // Reset mid-word discards the partial word
        send(AG_FMT_I8, 9'd0, 32'd1, 1'b0);
        send(AG_FMT_I8, 9'd0, 32'd2, 1'b0);
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_sat_count", 64'(sat_count), 64'd0);
        check("mid_rst_fmt_err", 64'(fmt_err), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        push(32'h4433_2211, 4'd4);
        send(AG_FMT_I8, 9'd0, 32'h11, 1'b0);
        send(AG_FMT_I8, 9'd0, 32'h22, 1'b0);
        send(AG_FMT_I8, 9'd0, 32'h33, 1'b0);
        send(AG_FMT_I8, 9'd0, 32'h44, 1'b0);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
